// File: rtl/rflp_sram_pkg.sv
// Shared types and defaults for the byte-writable register-file SRAM.
// Latency: none (declarations only).
// Backpressure: none.
package rflp_sram_pkg;

    typedef enum logic {S_INIT, S_READY} sram_state_t;

    localparam int DW_DEF  = 32;
    localparam int BW_DEF  = 8;
    localparam int RAW_DEF = 6;
    localparam int CAW_DEF = 2;

    // Number of byte lanes in a word
    function automatic int nb(input int dw, input int bw);
        return dw / bw;
    endfunction

endpackage

// File: rtl/rflp_sram_array.sv
// DEPTH x DW storage with per-lane write enables and a registered read port.
// Latency: read data valid one cycle after rd_en is sampled.
// Backpressure: none; one access per cycle, rd_en/wr_en mutually exclusive upstream.
module rflp_sram_array
    import rflp_sram_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int BW = BW_DEF,
    parameter int AW = RAW_DEF + CAW_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [nb(DW, BW)-1:0]    lane_en,
    input  logic [AW-1:0]            addr,
    input  logic [DW-1:0]            wdat,
    input  logic                     rd_en,
    output logic [DW-1:0]            rdat
);

    localparam int NB    = nb(DW, BW);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Lane-masked write; storage itself is never reset, the sweep clears it
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (lane_en[i]) begin
                    mem[addr][i*BW +: BW] <= wdat[i*BW +: BW];
                end
            end
        end
    end

    // Registered read port; holds its value when no read is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdat <= '0;
        end else if (rd_en) begin
            rdat <= mem[addr];
        end
    end

endmodule

// File: rtl/rflp_sram_bw.sv
// Single-port register-file SRAM with byte writes and a post-reset zero-fill sweep.
// Latency: read 1 cycle (2 with RFLP_SRAM_OUT_REG_EN); sweep DEPTH cycles after reset.
// Backpressure: BUSY high during the sweep, accesses dropped; otherwise always accepts.
module rflp_sram_bw
    import rflp_sram_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int BW  = BW_DEF,
    parameter int RAW = RAW_DEF,
    parameter int CAW = CAW_DEF
) (
    input  logic                 CLK,
    input  logic                 NRST,
    input  logic [DW-1:0]        DIN,
    input  logic [RAW-1:0]       RA,
    input  logic [CAW-1:0]       CA,
    input  logic [DW/BW-1:0]     NBE,
    input  logic                 NWRT,
    input  logic                 NCE,
    output logic [DW-1:0]        DO,
    output logic                 BUSY
);

    localparam int AW = RAW + CAW;
    localparam int NB = nb(DW, BW);

    if (DW % BW != 0) begin : g_bad_width
        $fatal(1, "rflp_sram_bw: DW must be a multiple of BW");
    end

    sram_state_t      state, state_nxt;
    logic [AW-1:0]    sweep_cnt;
    logic             arr_wr_en;
    logic [NB-1:0]    arr_lane_en;
    logic [AW-1:0]    arr_addr;
    logic [DW-1:0]    arr_wdat;
    logic             arr_rd_en;
    logic [DW-1:0]    arr_rdat;

    // State register; reset restarts the sweep immediately
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Leave the sweep on the edge that clears the last word
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (sweep_cnt == {AW{1'b1}}) state_nxt = S_READY;
            S_READY: state_nxt = S_READY;
            default: state_nxt = S_INIT;
        endcase
    end

    // Sweep address counter, advances one word per cycle while sweeping
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            sweep_cnt <= '0;
        end else if (state == S_INIT) begin
            sweep_cnt <= sweep_cnt + 1'b1;
        end
    end

    // Array port mux: sweep owns the port in S_INIT, user pins otherwise
    always_comb begin
        arr_wr_en   = 1'b0;
        arr_lane_en = '0;
        arr_addr    = {RA, CA};
        arr_wdat    = DIN;
        arr_rd_en   = 1'b0;
        if (state == S_INIT) begin
            arr_wr_en   = 1'b1;
            arr_lane_en = '1;
            arr_addr    = sweep_cnt;
            arr_wdat    = '0;
        end else begin
            arr_wr_en   = !NCE && !NWRT;
            arr_lane_en = ~NBE;
            arr_rd_en   = !NCE && NWRT;
        end
    end

    assign BUSY = (state == S_INIT);

    rflp_sram_array #(
        .DW (DW),
        .BW (BW),
        .AW (AW)
    ) u_array (
        .clk     (CLK),
        .rst_n   (NRST),
        .wr_en   (arr_wr_en),
        .lane_en (arr_lane_en),
        .addr    (arr_addr),
        .wdat    (arr_wdat),
        .rd_en   (arr_rd_en),
        .rdat    (arr_rdat)
    );

`ifdef RFLP_SRAM_OUT_REG_EN
    logic [DW-1:0] do_q;

    // Extra output stage, reloads every cycle so it tracks holds one cycle late
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            do_q <= '0;
        end else begin
            do_q <= arr_rdat;
        end
    end

    assign DO = do_q;
`else
    assign DO = arr_rdat;
`endif

endmodule
